// File: rtl/oflow_fsm_write.sv
// Write-side sequencer for the optical-flow history-frame buffer; owns per-slot end_pointers.
// Optional overflow_err output enabled by OFLOW_FSM_WRITE_OVERFLOW_EN.
`ifndef OFFSET_WIDTH
`define OFFSET_WIDTH 4
`endif
`ifndef ADDR_WIDTH
`define ADDR_WIDTH 8
`endif
`ifndef TOTAL_FRAME_NUM_WIDTH
`define TOTAL_FRAME_NUM_WIDTH 8
`endif
`ifndef NUM_OF_HISTORY_FRAMES_WIDTH
`define NUM_OF_HISTORY_FRAMES_WIDTH 3
`endif

module oflow_fsm_write_ep #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         reset_N,
  input  logic         clr,
  input  logic         ld,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);
  always_ff @(posedge clk or negedge reset_N)
    if (!reset_N)  q <= '0;
    else if (clr)  q <= '0;
    else if (ld)   q <= d;
endmodule

module oflow_fsm_write #(
  parameter int MAX_HISTORY = 5,
  parameter int MAX_LINES   = 2**`OFFSET_WIDTH
) (
  input  logic                                     clk,
  input  logic                                     reset_N,
  input  logic [`TOTAL_FRAME_NUM_WIDTH-1:0]        frame_num,
  input  logic [`NUM_OF_HISTORY_FRAMES_WIDTH-1:0]  num_of_history_frames,
  input  logic                                     start_write,
  input  logic                                     valid_in,
  input  logic                                     last_in,
  output logic                                     ready,
  output logic                                     we,
  output logic [`TOTAL_FRAME_NUM_WIDTH-1:0]        frame_to_write,
  output logic [`OFFSET_WIDTH-1:0]                 offset_0,
  output logic [`OFFSET_WIDTH-1:0]                 offset_1,
  output logic [MAX_HISTORY-1:0][`ADDR_WIDTH-1:0]  end_pointers,
`ifdef OFLOW_FSM_WRITE_OVERFLOW_EN
  output logic                                     overflow_err,
`endif
  output logic                                     done_write
);
  localparam int OW = `OFFSET_WIDTH;
  localparam int AW = `ADDR_WIDTH;
  localparam int FW = `TOTAL_FRAME_NUM_WIDTH;
  localparam int HW = `NUM_OF_HISTORY_FRAMES_WIDTH;
  localparam int SW = (MAX_HISTORY > 1) ? $clog2(MAX_HISTORY) : 1;

  localparam logic [1:0] IDLE_ST  = 2'd0;
  localparam logic [1:0] CLEAR_ST = 2'd1;
  localparam logic [1:0] WRITE_ST = 2'd2;
  localparam logic [1:0] DONE_ST  = 2'd3;

  logic [1:0]    state;
  logic [OW-1:0] counter_offset;
  logic [SW-1:0] slot;
  logic [HW-1:0] n_eff;
  logic          handshake, at_max, commit;
  logic [OW:0]   cnt_inc;
  logic [AW-1:0] commit_val;

  always_comb begin
    n_eff = num_of_history_frames;
    if (num_of_history_frames == '0)                   n_eff = HW'(1);
    else if (int'(num_of_history_frames) > MAX_HISTORY) n_eff = HW'(MAX_HISTORY);
  end

  assign ready      = (state == WRITE_ST);
  assign handshake  = valid_in && ready;
  assign we         = handshake;
  assign done_write = (state == DONE_ST);
  assign offset_0   = counter_offset;
  assign offset_1   = '0;
  assign at_max     = (counter_offset == OW'(MAX_LINES - 1));
  assign commit     = handshake && (last_in || at_max);
  // One extra bit so a full slot commits MAX_LINES rather than wrapping to 0.
  assign cnt_inc    = {1'b0, counter_offset} + {{OW{1'b0}}, 1'b1};
  assign commit_val = AW'(cnt_inc);

  always_ff @(posedge clk or negedge reset_N) begin
    if (!reset_N) begin
      state          <= IDLE_ST;
      counter_offset <= '0;
      slot           <= '0;
      frame_to_write <= '0;
    end else begin
      case (state)
        IDLE_ST: if (start_write) begin
          frame_to_write <= frame_num;
          slot           <= SW'(frame_num % FW'(n_eff));
          state          <= CLEAR_ST;
        end
        CLEAR_ST: begin
          counter_offset <= '0;
          state          <= WRITE_ST;
        end
        WRITE_ST: if (handshake) begin
          counter_offset <= counter_offset + 1'b1;
          if (commit) state <= DONE_ST;
        end
        default: state <= IDLE_ST;
      endcase
    end
  end

  for (genvar i = 0; i < MAX_HISTORY; i++) begin : g_slot
    oflow_fsm_write_ep #(.W(AW)) u_ep (
      .clk     (clk),
      .reset_N (reset_N),
      .clr     ((state == CLEAR_ST) && (slot == SW'(i))),
      .ld      (commit && (slot == SW'(i))),
      .d       (commit_val),
      .q       (end_pointers[i])
    );
  end

`ifdef OFLOW_FSM_WRITE_OVERFLOW_EN
  always_ff @(posedge clk or negedge reset_N) begin
    if (!reset_N)                                  overflow_err <= 1'b0;
    else if (state == IDLE_ST && start_write)      overflow_err <= 1'b0;
    else if (commit && !last_in)                   overflow_err <= 1'b1;
    else if (state == DONE_ST && valid_in)         overflow_err <= 1'b1;
  end
`endif
endmodule

// File: tb/tb_oflow_fsm_write.sv
// Scoreboard bench for oflow_fsm_write: driver queues expected writes/commits, monitor checks them.
`ifndef OFFSET_WIDTH
`define OFFSET_WIDTH 4
`endif
`ifndef ADDR_WIDTH
`define ADDR_WIDTH 8
`endif
`ifndef TOTAL_FRAME_NUM_WIDTH
`define TOTAL_FRAME_NUM_WIDTH 8
`endif
`ifndef NUM_OF_HISTORY_FRAMES_WIDTH
`define NUM_OF_HISTORY_FRAMES_WIDTH 3
`endif

module tb_oflow_fsm_write;
  localparam int MAXH = 5;
  localparam int MAXL = 2**`OFFSET_WIDTH;

  typedef struct {
    bit                             done;
    int                             off;
    int                             frame;
    logic [MAXH-1:0][`ADDR_WIDTH-1:0] ep;
  } exp_t;

  logic clk = 1'b0;
  logic reset_N;
  logic [`TOTAL_FRAME_NUM_WIDTH-1:0]       frame_num;
  logic [`NUM_OF_HISTORY_FRAMES_WIDTH-1:0] num_of_history_frames;
  logic start_write, valid_in, last_in;
  logic ready, we, done_write;
  logic [`TOTAL_FRAME_NUM_WIDTH-1:0]     frame_to_write;
  logic [`OFFSET_WIDTH-1:0]              offset_0, offset_1;
  logic [MAXH-1:0][`ADDR_WIDTH-1:0]      end_pointers;
`ifdef OFLOW_FSM_WRITE_OVERFLOW_EN
  logic overflow_err;
`endif

  oflow_fsm_write #(.MAX_HISTORY(MAXH), .MAX_LINES(MAXL)) dut (
    .clk                   (clk),
    .reset_N               (reset_N),
    .frame_num             (frame_num),
    .num_of_history_frames (num_of_history_frames),
    .start_write           (start_write),
    .valid_in              (valid_in),
    .last_in               (last_in),
    .ready                 (ready),
    .we                    (we),
    .frame_to_write        (frame_to_write),
    .offset_0              (offset_0),
    .offset_1              (offset_1),
    .end_pointers          (end_pointers),
`ifdef OFLOW_FSM_WRITE_OVERFLOW_EN
    .overflow_err          (overflow_err),
`endif
    .done_write            (done_write)
  );

  always #5 clk = ~clk;

  int   n_pass = 0;
  int   n_total = 0;
  int   cyc = 0;
  int   last_we_cyc = -10;
  exp_t q[$];
  logic [MAXH-1:0][`ADDR_WIDTH-1:0] ep_model = '0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    n_total++;
    if (act === req) n_pass++;
    else $display("FAIL %s: actual=%0h required=%0h (t=%0t)", name, act, req, $time);
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: samples on the falling edge, pops one expectation per DUT event.
  always @(negedge clk) begin
    exp_t e;
    if (reset_N === 1'b1) begin
      if (we) begin
        if (q.size() == 0 || q[0].done) check("unexpected_we", 64'(we), 64'd0);
        else begin
          e = q.pop_front();
          check("we_offset", 64'(offset_0), 64'(e.off));
          check("we_frame", 64'(frame_to_write), 64'(e.frame[`TOTAL_FRAME_NUM_WIDTH-1:0]));
          check("offset_1", 64'(offset_1), 64'd0);
          last_we_cyc = cyc;
        end
      end
      if (done_write) begin
        if (q.size() == 0 || !q[0].done) check("unexpected_done", 64'(done_write), 64'd0);
        else begin
          e = q.pop_front();
          check("done_latency", 64'(cyc), 64'(last_we_cyc + 1));
          check("done_end_pointers", 64'(end_pointers), 64'(e.ep));
          check("done_ready_low", 64'(ready), 64'd0);
        end
      end
    end
  end

  task automatic do_frame(input int fnum, input int nhist, input int lines, input int slot,
                          input bit use_last, input bit gaps, input bit dirty_done);
    exp_t e;
    @(posedge clk); #1;
    frame_num = fnum[`TOTAL_FRAME_NUM_WIDTH-1:0];
    num_of_history_frames = nhist[`NUM_OF_HISTORY_FRAMES_WIDTH-1:0];
    start_write = 1'b1;
    valid_in = 1'b1;  // ignored while idle
    @(posedge clk); #1;
    start_write = 1'b0;
    valid_in = 1'b0;
    frame_num = 8'hEE;  // must not disturb the latched frame
    @(posedge clk); #1;
    check("first_ready", 64'(ready), 64'd1);
    check("slot_cleared", 64'(end_pointers[slot]), 64'd0);
    for (int i = 0; i < lines; i++) begin
      if (gaps && i > 0) begin
        valid_in = 1'b0;
        start_write = 1'b1;
        @(posedge clk); #1;
        start_write = 1'b0;
      end
      valid_in = 1'b1;
      last_in = use_last && (i == lines - 1);
      e.done = 1'b0; e.off = i; e.frame = fnum; e.ep = '0;
      q.push_back(e);
      if (i == lines - 1) begin
        ep_model[slot] = 8'(lines);
        e.done = 1'b1; e.ep = ep_model;
        q.push_back(e);
      end
      @(posedge clk); #1;
    end
    valid_in = dirty_done;
    last_in = 1'b0;
    @(posedge clk); #1;
    valid_in = 1'b0;
  endtask

  initial begin
    exp_t e;
    reset_N = 1'b0; frame_num = '0; num_of_history_frames = '0;
    start_write = 1'b0; valid_in = 1'b0; last_in = 1'b0;
    #12;
    check("rst_ready", 64'(ready), 64'd0);
    check("rst_we", 64'(we), 64'd0);
    check("rst_done", 64'(done_write), 64'd0);
    check("rst_end_pointers", 64'(end_pointers), 64'd0);
    check("rst_frame_to_write", 64'(frame_to_write), 64'd0);
    check("rst_offset_0", 64'(offset_0), 64'd0);
    @(posedge clk); #1;
    reset_N = 1'b1;

    do_frame(7, 5, 3, 2, 1'b1, 1'b0, 1'b0);
`ifdef OFLOW_FSM_WRITE_OVERFLOW_EN
    check("ovf_normal_frame", 64'(overflow_err), 64'd0);
`endif
    for (int f = 10; f <= 14; f++) do_frame(f, 5, f - 9, f - 10, 1'b1, 1'b0, 1'b0);
    check("ep_after_10_14", 64'(end_pointers), 64'h05_04_03_02_01);
    do_frame(15, 5, 2, 0, 1'b1, 1'b0, 1'b0);
    do_frame(16, 5, 3, 1, 1'b1, 1'b1, 1'b0);
    do_frame(9, 0, 1, 0, 1'b1, 1'b0, 1'b0);
    do_frame(13, 7, 2, 3, 1'b1, 1'b0, 1'b0);
    do_frame(4, 5, MAXL, 4, 1'b0, 1'b0, 1'b1);
    check("ep_max_lines", 64'(end_pointers[4]), 64'(MAXL));
`ifdef OFLOW_FSM_WRITE_OVERFLOW_EN
    check("ovf_set", 64'(overflow_err), 64'd1);
`endif
    do_frame(20, 5, 1, 0, 1'b1, 1'b0, 1'b0);
`ifdef OFLOW_FSM_WRITE_OVERFLOW_EN
    check("ovf_cleared", 64'(overflow_err), 64'd0);
`endif

    // Reset in the middle of a frame after two lines.
    @(posedge clk); #1;
    frame_num = 8'd21; num_of_history_frames = 3'd5; start_write = 1'b1;
    @(posedge clk); #1; start_write = 1'b0;
    @(posedge clk); #1;
    for (int i = 0; i < 2; i++) begin
      valid_in = 1'b1; last_in = 1'b0;
      e.done = 1'b0; e.off = i; e.frame = 21; e.ep = '0;
      q.push_back(e);
      @(posedge clk); #1;
    end
    valid_in = 1'b0;
    #2 reset_N = 1'b0;
    valid_in = 1'b1;
    #1;
    check("midrst_ready", 64'(ready), 64'd0);
    check("midrst_we", 64'(we), 64'd0);
    check("midrst_done", 64'(done_write), 64'd0);
    check("midrst_end_pointers", 64'(end_pointers), 64'd0);
    ep_model = '0;
    @(posedge clk); #1;
    valid_in = 1'b0;
    reset_N = 1'b1;
    do_frame(22, 5, 1, 2, 1'b1, 1'b0, 1'b0);
    check("ep_after_reset", 64'(end_pointers), 64'h00_00_01_00_00);

    repeat (3) @(posedge clk);
    check("queue_drained", 64'(q.size()), 64'd0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: actual=timeout required=finish");
    $fatal(1);
  end
endmodule
